// File: rtl/bcd_divider_check_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_divider_check_sequencer
//
// Purpose: decides whether a DIGITS-digit BCD dividend is divisible by a
// single BCD divisor digit. The dividend is walked most-significant digit
// first, keeping a running remainder that is reduced by repeated subtraction.
// It uses a start/busy/done handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      request, sampled only in IDLE
//   dividend   BCD dividend (MSD in top nibble), latched at start
//   divisor    BCD divisor digit, latched at start
//   busy       high in every state except IDLE
//   done       one-cycle pulse when results are valid
//   isDivider  1 = divisor divides dividend exactly (held)
//   error      1 = divisor is 0 or a dividend nibble is >9 (held)
//   remainder  final remainder 0..8 (held)
//   quotient   BCD quotient, present only when BCD_QUOTIENT_EN is defined
//
// Optional feature macro: BCD_QUOTIENT_EN
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; results held
// CHECK  | validate latched operands, prime remainder and digit index
// SHIFT  | r = r*10 + current digit
// REDUCE | subtract divisor until r < divisor, then next digit or finish
// DONE   | done pulse, results visible; back to IDLE
// ---------------------------------------------------------------------------
module bcd_divider_check_sequencer #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   dividend,
  input  logic [3:0]            divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  isDivider,
  output logic                  error,
  output logic [3:0]            remainder
`ifdef BCD_QUOTIENT_EN
  ,
  output logic [4*DIGITS-1:0]   quotient
`endif
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] MSD_IDX = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SHIFT  = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_dvd;
  logic [3:0]            r_dvs;
  logic [6:0]            r_rem;
  logic [IW-1:0]         r_idx;

  logic [3:0]            w_digit;
  logic                  w_bad_nibble;
  logic [6:0]            w_shifted;
  logic                  w_ge;

`ifdef BCD_QUOTIENT_EN
  logic [3:0]            r_kcnt;
  logic [4*DIGITS-1:0]   r_qacc;
  logic [4*DIGITS-1:0]   w_qnext;
`endif

  always_comb begin
    w_digit      = 4'd0;
    w_bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) w_digit = r_dvd[i*4 +: 4];
      if (r_dvd[i*4 +: 4] > 4'd9) w_bad_nibble = 1'b1;
    end
  end

  // r is at most divisor-1 (<= 8) whenever SHIFT runs, so r*10+9 <= 89 fits 7 bits.
  assign w_shifted = 7'(r_rem * 7'd10) + {3'b000, w_digit};
  assign w_ge      = (r_rem >= {3'b000, r_dvs});

`ifdef BCD_QUOTIENT_EN
  // Quotient accumulator with the finished digit's subtraction count merged in.
  always_comb begin
    w_qnext = r_qacc;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) w_qnext[i*4 +: 4] = r_kcnt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      isDivider <= 1'b0;
      error     <= 1'b0;
      remainder <= '0;
`ifdef BCD_QUOTIENT_EN
      r_kcnt    <= '0;
      r_qacc    <= '0;
      quotient  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_dvd     <= dividend;
            r_dvs     <= divisor;
            isDivider <= 1'b0;
            error     <= 1'b0;
            remainder <= '0;
`ifdef BCD_QUOTIENT_EN
            quotient  <= '0;
`endif
            busy      <= 1'b1;
            r_state   <= S_CHECK;
          end
        end

        S_CHECK: begin
          if ((r_dvs == 4'd0) || w_bad_nibble) begin
            error     <= 1'b1;
            isDivider <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_rem   <= '0;
            r_idx   <= MSD_IDX;
`ifdef BCD_QUOTIENT_EN
            r_qacc  <= '0;
`endif
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_rem   <= w_shifted;
`ifdef BCD_QUOTIENT_EN
          r_kcnt  <= '0;
`endif
          r_state <= S_REDUCE;
        end

        S_REDUCE: begin
          if (w_ge) begin
            r_rem  <= r_rem - {3'b000, r_dvs};
`ifdef BCD_QUOTIENT_EN
            r_kcnt <= r_kcnt + 4'd1;
`endif
          end else begin
`ifdef BCD_QUOTIENT_EN
            r_qacc <= w_qnext;
`endif
            if (r_idx == '0) begin
              done      <= 1'b1;
              isDivider <= (r_rem == 7'd0);
              remainder <= r_rem[3:0];
`ifdef BCD_QUOTIENT_EN
              quotient  <= w_qnext;
`endif
              r_state   <= S_DONE;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_state <= S_SHIFT;
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_divider_check_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_divider_check_sequencer
//
// Purpose: self-checking bench for bcd_divider_check_sequencer (DIGITS=3).
// A transaction-level reference computes each operation's results and
// latency arithmetically; outputs are compared every cycle on the falling
// edge. Directed runs pin latency and results to hand-computed values.
// Honors BCD_QUOTIENT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_bcd_divider_check_sequencer;

  localparam int D = 3;
  localparam int W = 4 * D;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  dividend;
  logic [3:0]    divisor;
  logic          busy;
  logic          done;
  logic          isDivider;
  logic          error;
  logic [3:0]    remainder;
`ifdef BCD_QUOTIENT_EN
  logic [W-1:0]  quotient;
`endif

  bcd_divider_check_sequencer #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .isDivider (isDivider),
    .error     (error),
    .remainder (remainder)
`ifdef BCD_QUOTIENT_EN
    ,
    .quotient  (quotient)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: results and number of edges from accept to done.
  function automatic void ref_op(input logic [W-1:0] d, input logic [3:0] v,
                                 output int lat, output logic err, output logic isd,
                                 output logic [3:0] rem, output logic [W-1:0] q);
    int r;
    int k;
    int nib;
    err = (v == 4'd0);
    for (int i = 0; i < D; i++) if (d[i*4 +: 4] > 4'd9) err = 1'b1;
    q   = '0;
    isd = 1'b0;
    rem = 4'd0;
    lat = 1;
    if (err) return;
    r = 0;
    for (int i = D - 1; i >= 0; i--) begin
      nib = int'(d[i*4 +: 4]);
      r   = r * 10 + nib;
      k   = r / int'(v);
      r   = r % int'(v);
      lat = lat + k + 2;
      q[i*4 +: 4] = 4'(k);
    end
    isd = (r == 0);
    rem = 4'(r);
  endfunction

  // Model state: expected outputs after each rising edge.
  logic          m_busy = 1'b0, m_done = 1'b0, m_isd = 1'b0, m_err = 1'b0;
  logic [3:0]    m_rem = 4'd0;
  logic [W-1:0]  m_q = '0;
  int            m_left = 0;
  logic          p_err, p_isd;
  logic [3:0]    p_rem;
  logic [W-1:0]  p_q;
  int            p_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_isd = 1'b0; m_err = 1'b0;
      m_rem = 4'd0; m_q = '0; m_left = 0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start) begin
        ref_op(dividend, divisor, p_lat, p_err, p_isd, p_rem, p_q);
        m_busy = 1'b1; m_left = p_lat;
        m_isd = 1'b0; m_err = 1'b0; m_rem = 4'd0; m_q = '0;
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_isd = p_isd; m_err = p_err; m_rem = p_rem; m_q = p_q;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("isDivider", 32'(isDivider), 32'(m_isd));
      check("error", 32'(error), 32'(m_err));
      check("remainder", 32'(remainder), 32'(m_rem));
`ifdef BCD_QUOTIENT_EN
      check("quotient", 32'(quotient), 32'(m_q));
`endif
    end
  end

  // Directed run: called at a falling edge; waits for idle, pulses start and
  // measures edges until done (edge that samples start is edge 0).
  task automatic run_op(input logic [W-1:0] d, input logic [3:0] v, input int exp_edges,
                        input logic exp_isd, input logic exp_err, input logic [3:0] exp_rem,
                        input logic [W-1:0] exp_q, input bit poke, input string nm);
    int  g;
    int  n;
    bit  seen;
    g = 0;
    while (m_busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    dividend = d;
    divisor  = v;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = 4'($urandom);
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (poke) begin
        if (n == 2) start = 1'b1;
        if (n == 5) start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({nm, "_latency"}, 32'(n), 32'(exp_edges));
    check({nm, "_isDivider"}, 32'(isDivider), 32'(exp_isd));
    check({nm, "_error"}, 32'(error), 32'(exp_err));
    check({nm, "_remainder"}, 32'(remainder), 32'(exp_rem));
`ifdef BCD_QUOTIENT_EN
    check({nm, "_quotient"}, 32'(quotient), 32'(exp_q));
`else
    if (exp_q === 'x) $display("note: unexpected quotient literal");
`endif
  endtask

  initial begin
    logic [W-1:0] rd;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_isDivider", 32'(isDivider), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(12'h936, 4'd9, 12, 1'b1, 1'b0, 4'd0, 12'h104, 1'b0, "d936_9");
    run_op(12'h100, 4'd7, 12, 1'b0, 1'b0, 4'd2, 12'h014, 1'b0, "d100_7");
    run_op(12'h999, 4'd1, 34, 1'b1, 1'b0, 4'd0, 12'h999, 1'b0, "d999_1");
    run_op(12'h123, 4'd0,  1, 1'b0, 1'b1, 4'd0, 12'h000, 1'b0, "div0");
    run_op(12'h9A1, 4'd3,  1, 1'b0, 1'b1, 4'd0, 12'h000, 1'b0, "badnib");
    run_op(12'h936, 4'd9, 12, 1'b1, 1'b0, 4'd0, 12'h104, 1'b1, "restart_ign");
    run_op(12'h100, 4'd7, 12, 1'b0, 1'b0, 4'd2, 12'h014, 1'b0, "b2b");

    // Reset at edge 6 of a 999/1 run.
    dividend = 12'h999;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_isDivider", 32'(isDivider), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(12'h936, 4'd9, 12, 1'b1, 1'b0, 4'd0, 12'h104, 1'b0, "after_abort");

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 5000; c++) begin
      rst   = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < D; i++) rd[i*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) rd[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
      dividend = rd;
      divisor  = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
